pulpemu_uart_rx: RTL

Emulator-side UART receiver that terminates the PULP chip's UART TX pad on the FPGA, so the emulation platform can capture chip console output (printf) without an external USB-UART. It sits in the pulpemu top next to the reference-clock dividers, sampling the chip's uart_tx line in the fabric clock domain. Received bytes go into a small FIFO drained by a valid/ready consumer, normally a Zynq-side AXI register bridge. Framing and overrun errors are reported through sticky flags.

---
 rtl/pulpemu_uart_pkg.sv | 14 +
 rtl/pulpemu_uart_fifo.sv | 64 ++++++
 rtl/pulpemu_uart_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pulpemu_uart_pkg.sv
// rtl/pulpemu_uart_pkg.sv - shared types and constants for the pulpemu UART receiver
package pulpemu_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/pulpemu_uart_fifo.sv
// rtl/pulpemu_uart_fifo.sv - first-word fall-through byte FIFO with occupancy count
module pulpemu_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == FULL_CNT);
  assign count_o = r_count;
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pulpemu_uart_rx.sv
// rtl/pulpemu_uart_rx.sv - 8N1 UART receiver capturing chip console output into a byte FIFO
module pulpemu_uart_rx
  import pulpemu_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          clr_err_i
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [1:0]                r_sync;
  logic                      r_rxs_d;
  logic [2:0]                r_arm;
  rx_state_e                 r_state;
  logic [CW-1:0]             r_cnt;
  logic [BW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_rxs;
  logic w_tick;
  logic w_fall;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_stop_bad;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == '0);
  // Edges are ignored until the synchronizer and r_rxs_d hold real line samples, so a
  // line held low across reset release is not mistaken for a start bit.
  assign w_fall = r_arm[2] && r_rxs_d && !w_rxs;

  assign w_push     = (r_state == STOP) && w_tick && w_rxs;
  assign w_stop_bad = (r_state == STOP) && w_tick && !w_rxs;
  assign w_pop      = valid_o && ready_i;

  assign valid_o     = !w_empty;
  assign busy_o      = (r_state != IDLE);
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync      <= 2'b11;
      r_rxs_d     <= 1'b1;
      r_arm       <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_i};
      r_rxs_d <= w_rxs;
      r_arm   <= {r_arm[1:0], 1'b1};

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_cnt   <= HALF_M1;
            r_state <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_cnt     <= FULL_M1;
            r_bit_idx <= '0;
            r_state   <= w_rxs ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
            r_cnt   <= FULL_M1;
            if (r_bit_idx == LAST_BIT) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state <= w_rxs ? IDLE : WAIT_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (w_rxs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end else if (clr_err_i) begin
        r_frame_err <= 1'b0;
      end

      if (w_push && w_full && !w_pop) begin
        r_overrun <= 1'b1;
      end else if (clr_err_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  pulpemu_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (r_shift),
    .pop_i   (w_pop),
    .data_o  (data_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

endmodule
